// File: rtl/i2c_reg_bank.sv
// i2c_reg_bank: register bank behind the I2C slave, clocked by SCL.
// It turns received bytes into a register pointer and register writes,
// serves register contents to the transmit path on master reads, and
// exposes a combinational local read port plus a write strobe.
//
// Build option: define I2C_REG_AUTOINC_EN so the pointer advances after
// every register write and read. Without it, the pointer moves only when
// a pointer byte arrives, so repeated accesses hit the same register.
module i2c_reg_bank #(
  parameter int DEPTH = 16,
  parameter int PTR_W = 4
) (
  input  logic             SCL,
  input  logic             RST,
  input  logic             addr_hit,
  input  logic             rw,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  input  logic             tx_req,
  input  logic             stop,
  output logic [7:0]       tx_data,
  output logic             tx_valid,
  output logic             wr_stb,
  output logic [PTR_W-1:0] wr_addr,
  output logic [PTR_W-1:0] ptr,
  output logic             ptr_err,
  input  logic [PTR_W-1:0] host_addr,
  output logic [7:0]       host_rdata
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PTR   = 2'd1,
    WRITE = 2'd2,
    READ  = 2'd3
  } state_t;

  state_t     state;
  state_t     state_next;

  logic       ptr_load;
  logic       mem_we;
  logic       rd_en;
  logic       ptr_adv;
  logic       ptr_oob;

  logic [7:0] mem [DEPTH];

  // State register; reset aborts any transaction in flight.
  always_ff @(posedge SCL or posedge RST) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state: the byte is handled in the old state first, STOP then
  // returns to IDLE, and an address match overrides everything (repeated
  // start, and addr_hit wins over a simultaneous stop).
  always_comb begin
    state_next = state;
    if (state == PTR && rx_valid) begin
      state_next = WRITE;
    end
    if (stop) begin
      state_next = IDLE;
    end
    if (addr_hit) begin
      state_next = rw ? READ : PTR;
    end
  end

  // Datapath controls decoded from the current state and the byte pulses.
  always_comb begin
    ptr_load = 1'b0;
    mem_we   = 1'b0;
    rd_en    = 1'b0;
    unique case (state)
      PTR:     ptr_load = rx_valid;
      WRITE:   mem_we   = rx_valid;
      READ:    rd_en    = tx_req;
      default: ;
    endcase
  end

  // A pointer byte outside the bank is flagged but still used truncated.
  assign ptr_oob = (int'(rx_data) > (DEPTH - 1));

`ifdef I2C_REG_AUTOINC_EN
  assign ptr_adv = mem_we | rd_en;
`else
  assign ptr_adv = 1'b0;
`endif

  // Register pointer: loaded by the pointer byte, optionally advanced
  // after each access; wraps naturally at DEPTH because PTR_W = log2(DEPTH).
  always_ff @(posedge SCL or posedge RST) begin
    if (RST) begin
      ptr <= '0;
    end else if (ptr_load) begin
      ptr <= rx_data[PTR_W-1:0];
    end else if (ptr_adv) begin
      ptr <= ptr + PTR_W'(1);
    end
  end

  // Sticky out-of-range pointer flag; only reset clears it.
  always_ff @(posedge SCL or posedge RST) begin
    if (RST) begin
      ptr_err <= 1'b0;
    end else if (ptr_load && ptr_oob) begin
      ptr_err <= 1'b1;
    end
  end

  // Register array; cleared by reset so the host port reads zeros after it.
  always_ff @(posedge SCL or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= 8'h00;
      end
    end else if (mem_we) begin
      mem[ptr] <= rx_data;
    end
  end

  // Write strobe and the index that was written, one cycle after the byte.
  always_ff @(posedge SCL or posedge RST) begin
    if (RST) begin
      wr_stb  <= 1'b0;
      wr_addr <= '0;
    end else begin
      wr_stb <= mem_we;
      if (mem_we) begin
        wr_addr <= ptr;
      end
    end
  end

  // Transmit byte: loaded on a serviced request, otherwise held.
  always_ff @(posedge SCL or posedge RST) begin
    if (RST) begin
      tx_data  <= 8'h00;
      tx_valid <= 1'b0;
    end else begin
      tx_valid <= rd_en;
      if (rd_en) begin
        tx_data <= mem[ptr];
      end
    end
  end

  // Local read port, combinational.
  assign host_rdata = mem[host_addr];

endmodule

// File: tb/tb_i2c_reg_bank.sv
// Self-checking bench for i2c_reg_bank: directed steps from the test plan
// followed by randomized transactions, all checked against a transaction-
// level model (array of register values, pointer, sticky error flag).
module tb_i2c_reg_bank;

  localparam int DEPTH = 16;
  localparam int PTR_W = 4;
`ifdef I2C_REG_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif

  logic             SCL = 1'b0;
  logic             RST;
  logic             addr_hit;
  logic             rw;
  logic [7:0]       rx_data;
  logic             rx_valid;
  logic             tx_req;
  logic             stop;
  logic [7:0]       tx_data;
  logic             tx_valid;
  logic             wr_stb;
  logic [PTR_W-1:0] wr_addr;
  logic [PTR_W-1:0] ptr;
  logic             ptr_err;
  logic [PTR_W-1:0] host_addr;
  logic [7:0]       host_rdata;

  i2c_reg_bank #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .SCL(SCL), .RST(RST), .addr_hit(addr_hit), .rw(rw),
    .rx_data(rx_data), .rx_valid(rx_valid), .tx_req(tx_req), .stop(stop),
    .tx_data(tx_data), .tx_valid(tx_valid), .wr_stb(wr_stb),
    .wr_addr(wr_addr), .ptr(ptr), .ptr_err(ptr_err),
    .host_addr(host_addr), .host_rdata(host_rdata)
  );

  always #5 SCL = ~SCL;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model
  logic [7:0] m_mem [DEPTH];
  int         m_ptr;
  bit         m_err;
  logic [7:0] m_tx;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m_mem[i] = 8'h00;
    m_ptr = 0;
    m_err = 1'b0;
    m_tx  = 8'h00;
  endtask

  function automatic void model_adv();
    if (AUTOINC) m_ptr = (m_ptr + 1) % DEPTH;
  endfunction

  // One clock: inputs set before the call are sampled at the edge, outputs
  // are checked 1ns later, pulses are dropped for the next cycle.
  task automatic tick();
    @(posedge SCL);
    #1;
    addr_hit = 1'b0;
    rx_valid = 1'b0;
    tx_req   = 1'b0;
    stop     = 1'b0;
  endtask

  task automatic check_mem(input string tag);
    for (int i = 0; i < DEPTH; i++) begin
      host_addr = PTR_W'(i);
      #1;
      check(tag, host_rdata, m_mem[i]);
    end
  endtask

  task automatic start(input bit dir);
    addr_hit = 1'b1;
    rw       = dir;
    tick();
  endtask

  task automatic send_ptr(input logic [7:0] p);
    rx_valid = 1'b1;
    rx_data  = p;
    tick();
    m_ptr = int'(p) % DEPTH;
    if (int'(p) > DEPTH - 1) m_err = 1'b1;
    check("ptr_load", ptr, m_ptr);
    check("ptr_err", ptr_err, m_err);
    check("no_stb_on_ptr", wr_stb, 0);
  endtask

  task automatic send_data(input logic [7:0] b, input bit with_stop);
    rx_valid = 1'b1;
    rx_data  = b;
    stop     = with_stop;
    tick();
    check("wr_stb", wr_stb, 1);
    check("wr_addr", wr_addr, m_ptr);
    m_mem[m_ptr] = b;
    host_addr = PTR_W'(m_ptr);
    #1;
    check("host_rdata_wr", host_rdata, b);
    model_adv();
    check("ptr_after_wr", ptr, m_ptr);
  endtask

  task automatic do_read();
    tx_req = 1'b1;
    tick();
    check("tx_valid", tx_valid, 1);
    check("tx_data", tx_data, m_mem[m_ptr]);
    m_tx = m_mem[m_ptr];
    model_adv();
    check("ptr_after_rd", ptr, m_ptr);
  endtask

  task automatic end_txn();
    stop = 1'b1;
    tick();
    check("stb_idle", wr_stb, 0);
    check("tx_valid_idle", tx_valid, 0);
  endtask

  task automatic write_txn(input logic [7:0] p, input logic [7:0] d[$], input bit stop_last);
    start(1'b0);
    send_ptr(p);
    for (int i = 0; i < d.size(); i++)
      send_data(d[i], stop_last && (i == d.size() - 1));
    if (!(stop_last && d.size() > 0)) end_txn();
  endtask

  task automatic read_txn(input int n);
    start(1'b1);
    for (int i = 0; i < n; i++) do_read();
    tick();
    check("tx_valid_one_cycle", tx_valid, 0);
    check("tx_data_hold", tx_data, m_tx);
    end_txn();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] q[$];
    RST = 1'b1; addr_hit = 0; rw = 0; rx_data = 0; rx_valid = 0;
    tx_req = 0; stop = 0; host_addr = 0;
    model_reset();
    #2;
    check("rst_tx_data", tx_data, 0);
    check("rst_tx_valid", tx_valid, 0);
    check("rst_wr_stb", wr_stb, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_ptr", ptr, 0);
    check("rst_ptr_err", ptr_err, 0);
    @(posedge SCL); #1;
    RST = 1'b0;
    check_mem("rst_mem");

    // Pointer 3, two data bytes
    q = '{8'hA5, 8'h5A};
    write_txn(8'h03, q, 1'b0);
    check_mem("mem_after_w1");

    // Pointer-only write, then read three registers
    q = {};
    write_txn(8'h02, q, 1'b0);
    read_txn(3);

    // Wrap at the top of the bank
    q = '{8'h11, 8'h22};
    write_txn(8'h0F, q, 1'b0);
    check_mem("mem_after_wrap");

    // Out-of-range pointer: truncated, sticky flag survives stop
    q = {};
    write_txn(8'h23, q, 1'b0);
    tick();
    check("ptr_err_sticky", ptr_err, 1);
    check("ptr_trunc", ptr, 3);

    // stop together with addr_hit(read): addr_hit wins
    start(1'b0);
    send_ptr(8'h06);
    stop = 1'b1; addr_hit = 1'b1; rw = 1'b1;
    tick();
    do_read();
    end_txn();

    // Data byte together with addr_hit(read): written, then READ
    start(1'b0);
    send_ptr(8'h08);
    rx_valid = 1'b1; rx_data = 8'h77; addr_hit = 1'b1; rw = 1'b1;
    tick();
    check("wr_stb_with_hit", wr_stb, 1);
    check("wr_addr_with_hit", wr_addr, m_ptr);
    m_mem[m_ptr] = 8'h77;
    model_adv();
    do_read();
    end_txn();

    // Ignored inputs in IDLE and READ
    rx_valid = 1'b1; rx_data = 8'hEE;
    tick();
    check("rx_ignored_idle", wr_stb, 0);
    tx_req = 1'b1;
    tick();
    check("tx_ignored_idle", tx_valid, 0);
    check("tx_hold_idle", tx_data, m_tx);
    start(1'b1);
    rx_valid = 1'b1; rx_data = 8'h99;
    tick();
    check("rx_ignored_read", wr_stb, 0);
    check("ptr_unchanged_read", ptr, m_ptr);
    end_txn();
    check_mem("mem_after_ignored");

    // Randomized transactions
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 1) == 0) begin
        q = {};
        for (int k = 0; k < int'($urandom_range(0, 4)); k++) q.push_back(8'($urandom));
        write_txn(8'($urandom_range(0, 40)), q, 1'($urandom_range(0, 1)));
      end else begin
        read_txn(int'($urandom_range(1, 4)));
      end
      check("rand_ptr", ptr, m_ptr);
      check("rand_ptr_err", ptr_err, m_err);
      if (it % 8 == 7) check_mem("rand_mem");
    end

    // Reset between data bytes of a write
    start(1'b0);
    send_ptr(8'h05);
    send_data(8'h3C, 1'b0);
    #2;
    RST = 1'b1;
    #1;
    model_reset();
    check("midrst_tx_data", tx_data, 0);
    check("midrst_tx_valid", tx_valid, 0);
    check("midrst_wr_stb", wr_stb, 0);
    check("midrst_wr_addr", wr_addr, 0);
    check("midrst_ptr", ptr, 0);
    check("midrst_ptr_err", ptr_err, 0);
    tick();
    RST = 1'b0;
    rx_valid = 1'b1; rx_data = 8'h44;
    tick();
    check("postrst_rx_ignored", wr_stb, 0);
    check("postrst_ptr", ptr, 0);
    check_mem("postrst_mem");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
